// File: rtl/mux_scan_pkg.sv
// Shared types and widths for the 4:1 mux scan controller.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter: cleared at the start of each channel, counts while
// enabled, and flags the last settle cycle.
module settle_timer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic term_c
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term_c = (cnt == TERM);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks the mux selects through channels 0..3, waits SETTLE cycles on each,
// samples y and publishes the four bits as one word with a done pulse.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              y,
    output logic              s1,
    output logic              s0,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] data
);

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  sel, sel_nxt;
    logic [NUM_CH-1:0] shadow, shadow_nxt;
    logic [NUM_CH-1:0] data_nxt;
    logic              busy_nxt, done_nxt;
    logic              cnt_clear, cnt_en, term_c;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .en     (cnt_en),
        .term_c (term_c)
    );

    // State and all output-facing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sel    <= '0;
            shadow <= '0;
            data   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            shadow <= shadow_nxt;
            data   <= data_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state logic; busy/done are registered copies of the next state.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        shadow_nxt = shadow;
        data_nxt   = data;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    sel_nxt   = '0;
                    cnt_clear = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_en = 1'b1;
                if (term_c) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                shadow_nxt[sel] = y;
                if (sel == SEL_W'(NUM_CH - 1)) begin
                    // Publish the full word, including the bit taken this cycle.
                    data_nxt  = shadow_nxt;
                    state_nxt = ST_DONE;
                end else begin
                    sel_nxt   = sel + SEL_W'(1);
                    cnt_clear = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (cont) begin
                    sel_nxt   = '0;
                    cnt_clear = 1'b1;
                    state_nxt = ST_SETTLE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE);
        done_nxt = (state_nxt == ST_DONE);
    end

    assign s1 = sel[1];
    assign s0 = sel[0];

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: two instances (SETTLE=2 and SETTLE=1)
// scan a modelled 4:1 mux under directed and random start/cont/input traffic.
module tb_mux_scan_ctrl;

    typedef struct {
        int         launch;
        logic [3:0] data;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont  = 1'b0;
    logic [3:0] ins   = 4'b0000;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned S = (g == 0) ? 2 : 1;

        logic       s1, s0, busy, done, y;
        logic [3:0] data;

        exp_t exp_q[$];
        int   c      = 0;
        int   launch = -1;
        int   dn     = -1;
        logic       m_busy = 1'b0;
        logic       m_done = 1'b0;
        logic [1:0] m_sel  = 2'b00;
        logic [3:0] m_data = 4'b0000;

        // 4:1 mux: y follows the input selected by {s1,s0}.
        assign y = ins[{s1, s0}];

        mux_scan_ctrl #(.SETTLE(S)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .cont  (cont),
            .y     (y),
            .s1    (s1),
            .s0    (s0),
            .busy  (busy),
            .done  (done),
            .data  (data)
        );

        // Reference model: each channel k occupies S+1 cycles after launch,
        // and its bit is the mux input present at the edge closing that slot.
        always @(posedge clk) begin
            exp_t e;
            int   t;
            int   k;
            c      = c + 1;
            m_done = 1'b0;
            if (!rst_n) begin
                launch = -1;
                dn     = -1;
                exp_q.delete();
                m_busy = 1'b0;
                m_sel  = 2'b00;
                m_data = 4'b0000;
            end else if (dn >= 0 || launch < 0) begin
                if ((dn >= 0) ? cont : start) begin
                    launch   = c;
                    m_sel    = 2'b00;
                    m_busy   = 1'b1;
                    e.launch = c;
                    e.data   = 4'b0000;
                    exp_q.push_back(e);
                end
                dn = -1;
            end else begin
                t = c - launch;
                if (t % (S + 1) == 0) begin
                    k = t / (S + 1) - 1;
                    e = exp_q.pop_back();
                    e.data[k] = ins[k];
                    exp_q.push_back(e);
                    if (k == 3) begin
                        dn     = c;
                        launch = -1;
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_data = e.data;
                    end else begin
                        m_sel = 2'(k + 1);
                    end
                end
            end
        end

        // Monitor: compares every cycle and retires one scoreboard entry per done.
        always @(negedge clk) begin
            exp_t e;
            if (!rst_n) begin
                check($sformatf("reset_outputs_s%0d", S), int'({busy, done, s1, s0, data}), 0);
            end else begin
                check($sformatf("busy_s%0d", S), int'(busy), int'(m_busy));
                check($sformatf("sel_s%0d", S), int'({s1, s0}), int'(m_sel));
                check($sformatf("done_s%0d", S), int'(done), int'(m_done));
                check($sformatf("data_hold_s%0d", S), int'(data), int'(m_data));
                if (done && m_done) begin
                    e = exp_q.pop_front();
                    check($sformatf("scan_data_s%0d_launch%0d", S, e.launch), int'(data), int'(e.data));
                end
            end
        end
    end

    // One start pulse; measures done latency, counts done pulses and checks
    // the select walk, optionally re-pulsing start mid-scan.
    task automatic run_scan(input int restart_at, input logic [3:0] want);
        int lat0 = -1;
        int lat1 = -1;
        int nd0  = 0;
        int nd1  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (n > 0) step();
            start = (n == restart_at);
            if (g_dut[0].done) begin
                nd0++;
                if (lat0 < 0) lat0 = n;
            end
            if (g_dut[1].done) begin
                nd1++;
                if (lat1 < 0) lat1 = n;
            end
            if (n < 12) check("sel_walk_s2", int'({g_dut[0].s1, g_dut[0].s0}), n / 3);
            if (n < 8)  check("sel_walk_s1", int'({g_dut[1].s1, g_dut[1].s0}), n / 2);
        end
        start = 1'b0;
        check("latency_s2", lat0, 12);
        check("latency_s1", lat1, 8);
        check("done_pulses_s2", nd0, 1);
        check("done_pulses_s1", nd1, 1);
        check("word_s2", int'(g_dut[0].data), int'(want));
        check("word_s1", int'(g_dut[1].data), int'(want));
        check("idle_after_s2", int'(g_dut[0].busy), 0);
    endtask

    task automatic wait_done0(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!g_dut[0].done && n < 40);
    endtask

    initial begin
        int w;

        repeat (3) step();
        rst_n = 1'b1;
        step();

        ins = 4'b1011;
        run_scan(-1, 4'b1011);

        ins = 4'b0101;
        run_scan(5, 4'b0101);

        // Continuous mode: inputs change during the first DONE cycle.
        cont  = 1'b1;
        ins   = 4'b0110;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done0(w);
        check("cont_first_latency", w, 12);
        check("cont_first_word", int'(g_dut[0].data), 4'b0110);
        ins = 4'b1001;
        wait_done0(w);
        check("cont_period", w, 13);
        check("cont_second_word", int'(g_dut[0].data), 4'b1001);
        cont = 1'b0;
        repeat (30) step();

        // Asynchronous reset in the middle of a scan, between clock edges.
        ins   = 4'b0011;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_s2", int'({g_dut[0].busy, g_dut[0].done, g_dut[0].s1, g_dut[0].s0, g_dut[0].data}), 0);
        check("async_reset_s1", int'({g_dut[1].busy, g_dut[1].done, g_dut[1].s1, g_dut[1].s0, g_dut[1].data}), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        ins = 4'b1100;
        run_scan(-1, 4'b1100);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            ins   = 4'($urandom);
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) cont = ~cont;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
            end
            step();
        end
        start = 1'b0;
        cont  = 1'b0;
        repeat (40) step();
        check("pending_scans_s2", g_dut[0].exp_q.size(), 0);
        check("pending_scans_s1", g_dut[1].exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
